// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC selects, fetch exception codes,
// the NOP word, FSM states and default fetch addresses.
package if_stage_pkg;

  typedef enum logic [1:0] {
    PcSeq    = 2'b00,
    PcBranch = 2'b01,
    PcJump   = 2'b10,
    PcRs     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StDrop  = 2'b10
  } if_state_e;

  localparam logic [4:0] VecNone     = 5'd0;
  localparam logic [4:0] VecMisalign = 5'd1;
  localparam logic [4:0] VecIrq      = 5'd2;

  localparam logic [31:0] Nop = 32'h0000_0000;

  localparam logic [31:0] DefResetPc = 32'h0000_0000;
  localparam logic [31:0] DefExcPc   = 32'h0000_0080;

endpackage

// File: rtl/pc_mux.sv
// Combinational next-PC selection: sequential, branch target, region jump or register target.
module pc_mux
  import if_stage_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] branch_i,
  input  logic [3:0]  pc_4_hi_i,
  input  logic [27:0] offset28_i,
  input  logic [31:0] rs_i,
  output logic [31:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    unique case (sel_i)
      PcSeq:    next_pc_o = pc_i + 32'd4;
      PcBranch: next_pc_o = branch_i;
      PcJump:   next_pc_o = {pc_4_hi_i, offset28_i};
      PcRs:     next_pc_o = rs_i;
      default:  next_pc_o = pc_i + 32'd4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM (idle/fetch/drop), fetch exceptions and the
// IF/ID output register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefResetPc,
  parameter logic [31:0] EXC_PC   = DefExcPc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch,
  input  logic [27:0] offset28,
  input  logic [31:0] rs,
  input  logic        int_req,
  input  logic        s_u,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_4_out,
  output logic [31:0] ins,
  output logic [4:0]  vector_if,
  output logic        valid_out
);

  if_state_e   st_q, st_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc4_q, pc4_d;
  logic [4:0]  vec_q, vec_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic        misaligned;
  logic        irq_take;
  logic [1:0]  mux_sel;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;

  // Decode only acts on a redirect when it holds a real instruction and is not stalled.
  assign redirect   = (pc_src != PcSeq) && valid_q && !stall;
  assign mux_sel    = redirect ? pc_src : PcSeq;
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign irq_take   = int_req && s_u;
  assign pc_plus4   = pc_q + 32'd4;

  pc_mux u_pc_mux (
    .sel_i      (mux_sel),
    .pc_i       (pc_q),
    .branch_i   (branch),
    .pc_4_hi_i  (pc4_q[31:28]),
    .offset28_i (offset28),
    .rs_i       (rs),
    .next_pc_o  (next_pc)
  );

  always_comb begin
    st_d        = st_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    ins_d       = ins_q;
    pc4_d       = pc4_q;
    vec_d       = vec_q;
    valid_d     = valid_q;
    imem_req    = 1'b0;
    imem_addr   = pc_q;

    unique case (st_q)
      StIdle: begin
        st_d = StFetch;
      end

      StFetch: begin
        imem_req = !misaligned;
        if (!stall) begin
          if (redirect) begin
            pc_d    = next_pc;
            valid_d = 1'b0;
            // An unanswered request must still be drained before fetching the target.
            if (!misaligned && !imem_ready) begin
              st_d        = StDrop;
              drop_addr_d = pc_q;
            end
          end else if (misaligned) begin
            pc_d    = EXC_PC;
            ins_d   = Nop;
            pc4_d   = pc_plus4;
            vec_d   = VecMisalign;
            valid_d = 1'b1;
          end else if (imem_ready) begin
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            if (irq_take) begin
              ins_d = Nop;
              vec_d = VecIrq;
              pc_d  = EXC_PC;
            end else begin
              ins_d = imem_rdata;
              vec_d = VecNone;
              pc_d  = next_pc;
            end
          end else begin
            valid_d = 1'b0;
          end
        end
      end

      StDrop: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (imem_ready && !stall) begin
          st_d = StFetch;
        end
      end

      default: begin
        st_d = StIdle;
      end
    endcase

    // Flush overrides both the load and a stall hold of the IF/ID register.
    if (flush) begin
      ins_d   = Nop;
      vec_d   = VecNone;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q        <= StIdle;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      ins_q       <= Nop;
      pc4_q       <= 32'h0;
      vec_q       <= VecNone;
      valid_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      ins_q       <= ins_d;
      pc4_q       <= pc4_d;
      vec_q       <= vec_d;
      valid_q     <= valid_d;
    end
  end

  assign ins       = ins_q;
  assign pc_4_out  = pc4_q;
  assign vector_if = vec_q;
  assign valid_out = valid_q;

endmodule
